// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared defines for the pipeline sequencer.
//   - stall vector encodings (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
//   - MEM-stage exception codes
//   - common constants and the sequencer state type
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXC_INV_INST  = 32'h0000_000A;
  localparam logic [31:0] EXC_OVERFLOW  = 32'h0000_000C;
  localparam logic [31:0] EXC_TRAP      = 32'h0000_000D;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000E;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;

  // Two-bit encoding leaves spare codes; those recover to ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01
  } state_t;

endpackage

// File: rtl/pipe_stall_enc.sv
// pipe_stall_enc: combinational priority encoder from per-stage stall
// requests to the 6-bit stall vector. MEM > EX > ID > IF; a request holds
// its own stage and every earlier stage, so lower requests are masked.
// Ports:
//   stallreq_if_i/id_i/ex_i/mem_i : per-stage hold requests
//   stall_o                       : stall vector (1 = hold)
import pipe_ctrl_pkg::*;

module pipe_stall_enc (
  input  logic       stallreq_if_i,
  input  logic       stallreq_id_i,
  input  logic       stallreq_ex_i,
  input  logic       stallreq_mem_i,
  output logic [5:0] stall_o
);

  always_comb begin
    stall_o = STALL_NONE;
    if (stallreq_mem_i == Stop)
      stall_o = STALL_MEM;
    else if (stallreq_ex_i == Stop)
      stall_o = STALL_EX;
    else if (stallreq_id_i == Stop)
      stall_o = STALL_ID;
    else if (stallreq_if_i == Stop)
      stall_o = STALL_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the 5-stage core.
//   - stall arbitration (combinational, only while in RUN)
//   - exception/ERET redirect: flush all stages for FLUSH_CYCLES cycles and
//     present the new fetch address on new_pc_o while flushing
// Optional build macro PIPE_CTRL_WDOG_EN adds a stall watchdog and the
// wdog_timeout_o output (sticky until rst).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   stallreq_*_i        : stage hold requests (IF, ID, EX, MEM)
//   excepttype_i        : MEM-stage exception code, 0 = none
//   epc_i               : EPC used as the ERET target
//   stall_o             : stall vector, bit0 PC .. bit5 WB
//   flush_o             : clear all stage registers
//   new_pc_o            : redirect address, valid while flush_o=1
//   busy_o              : sequencer not in RUN
//   wdog_timeout_o      : (PIPE_CTRL_WDOG_EN only) stall watchdog fired
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          WDOG_LIMIT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
`ifdef PIPE_CTRL_WDOG_EN
  ,
  output logic        wdog_timeout_o
`endif
);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
      $error("pipe_ctrl: FLUSH_CYCLES must be within 1..15");
    end
    if (WDOG_LIMIT < 1 || WDOG_LIMIT > 65535) begin : g_bad_wdog_limit
      $error("pipe_ctrl: WDOG_LIMIT must be within 1..65535");
    end
  endgenerate

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  flush_cnt_reg;
  logic [5:0]  stall_enc;

  pipe_stall_enc u_stall_enc (
    .stallreq_if_i  (stallreq_if_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .stall_o        (stall_enc)
  );

  // Stages need the hold in the same cycle, so this stays combinational.
  // Held at zero while flushing and while reset is asserted.
  always_comb begin
    stall_o = STALL_NONE;
    if (state_reg == ST_RUN && rst != RstEnable)
      stall_o = stall_enc;
  end

  // Redirect sequencer. An exception seen in RUN wins over any stall in the
  // same cycle; while in FLUSH all requests and exceptions are ignored.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 4'd0;
      flush_o       <= 1'b0;
      new_pc_o      <= ZeroWord;
      busy_o        <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (excepttype_i != ZeroWord) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= FLUSH_LOAD;
            flush_o       <= 1'b1;
            busy_o        <= 1'b1;
            new_pc_o      <= (excepttype_i == EXC_ERET) ? epc_i : EXC_VECTOR;
          end else begin
            flush_o  <= 1'b0;
            busy_o   <= 1'b0;
            new_pc_o <= ZeroWord;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg == 4'd0) begin
            state_reg <= ST_RUN;
            flush_o   <= 1'b0;
            busy_o    <= 1'b0;
            new_pc_o  <= ZeroWord;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg     <= ST_RUN;
          flush_cnt_reg <= 4'd0;
          flush_o       <= 1'b0;
          new_pc_o      <= ZeroWord;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  // Counts consecutive stalled cycles. The timeout flag rises on the same
  // edge the count reaches WDOG_LIMIT and is sticky until reset.
  logic [15:0] wdog_cnt_reg;
  logic [16:0] wdog_cnt_inc;

  assign wdog_cnt_inc = {1'b0, wdog_cnt_reg} + 17'd1;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wdog_cnt_reg   <= 16'd0;
      wdog_timeout_o <= 1'b0;
    end else if (stall_o == STALL_NONE || flush_o) begin
      wdog_cnt_reg <= 16'd0;
    end else begin
      if (wdog_cnt_reg != 16'hFFFF)
        wdog_cnt_reg <= wdog_cnt_inc[15:0];
      if (wdog_cnt_inc >= 17'(WDOG_LIMIT))
        wdog_timeout_o <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. Arbitrates stall requests from IF/ID/EX/MEM into the 6-bit stall vector consumed by the PC register and the inter-stage registers.
- Sequences exception/ERET redirects: flushes all stages and supplies the new fetch address to the PC register.
- Sits beside the pipeline, between the MEM-stage exception logic and the PC/stage registers.

Parameters:
- EXC_VECTOR, 32'h0000_0020, fetch address for all exceptions except ERET.
- FLUSH_CYCLES, 1, cycles flush_o stays high per redirect (1..15).
- WDOG_LIMIT, 1023, consecutive-stall limit (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stallreq_if_i  in  1  IF stage requests a hold.
- stallreq_id_i  in  1  ID stage requests a hold.
- stallreq_ex_i  in  1  EX stage requests a hold (multi-cycle div/madd).
- stallreq_mem_i  in  1  MEM stage requests a hold.
- excepttype_i  in  32  MEM-stage exception code; 0 means none.
- epc_i  in  32  current EPC for ERET.
- stall_o  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 means hold.
- flush_o  out  1  clear all stage registers.
- new_pc_o  out  32  redirect address; valid only while flush_o=1.
- busy_o  out  1  FSM is not in RUN.

Behaviour:
- Reset: state RUN, stall_o=0, flush_o=0, new_pc_o=0, flush counter=0, busy_o=0.
- stall_o is combinational in RUN (same-cycle effect required by the stages). Priority: mem → 6'b011111; else ex → 6'b001111; else id → 6'b000111; else if → 6'b000011; else 0. Lower requests are masked by higher ones.
- RUN, excepttype_i≠0 at edge N:
  - Go to FLUSH at edge N; flush_o=1 in cycle N+1. Stall requests from cycle N are ignored.
  - new_pc_o = epc_i sampled at edge N if excepttype_i=32'hE (ERET); otherwise EXC_VECTOR.
  - Load the counter with FLUSH_CYCLES-1.
- FLUSH:
  - flush_o=1, stall_o=0, new_pc_o held, busy_o=1.
  - Stall requests and further exceptions are ignored.
  - Counter decrements; at 0, return to RUN on the next edge with flush_o=0 and new_pc_o=0.
- Exception and stall in the same RUN cycle: stall_o still follows requests in that cycle (combinational), and the redirect wins at the edge.
- Exception on the first RUN cycle after FLUSH is accepted normally, so back-to-back redirects are legal.
- rst during FLUSH: immediate return to reset values on that edge; the pending redirect is dropped.
- Illegal state encoding recovers to RUN.
- Width rules: all addresses are 32-bit. Counter is 4 bits; FLUSH_CYCLES outside 1..15 is a synthesis-time error.

Optional Feature:
- Macro: PIPE_CTRL_WDOG_EN.
- Enabled:
  - Adds output wdog_timeout_o (1 bit).
  - A 16-bit counter increments each cycle stall_o≠0 and clears on any cycle with stall_o=0 or flush_o=1.
  - When the counter reaches WDOG_LIMIT, wdog_timeout_o is set (registered, next edge) and stays set until rst. The counter saturates.
- Disabled: no port, no counter; behaviour otherwise identical.

Decomposition:
- Shared defines package:
  - Stall vector encodings (STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM).
  - Exception codes: interrupt 1, syscall 8, invalid inst 0xA, overflow 0xC, trap 0xD, ERET 0xE.
  - ZeroWord; RstEnable; Stop/NoStop.
- One sub-module, pipe_stall_enc: purely combinational priority encoder from the four requests to stall_o. The FSM, counter and redirect registers stay in pipe_ctrl.

Test Plan:
- Reset: assert rst 3 cycles with all requests high → stall_o=0, flush_o=0, new_pc_o=0, busy_o=0.
- Priority: stallreq_id_i=1 and stallreq_if_i=1 → stall_o=6'b000111; add stallreq_mem_i → 6'b011111 in the same cycle.
- Exception: excepttype_i=8 for 1 cycle at edge N → flush_o=1 and new_pc_o=32'h20 in cycle N+1 only (FLUSH_CYCLES=1), stall_o=0 that cycle.
- ERET with stall: excepttype_i=32'hE, epc_i=32'h0000_1234, stallreq_ex_i=1 → stall_o=6'b001111 that cycle, then flush_o=1 and new_pc_o=32'h1234.
- FLUSH_CYCLES=3 with a second exception and stallreq_mem_i during FLUSH → both ignored; flush_o high exactly 3 cycles; rst in the 2nd cycle → flush_o=0 next cycle.
- PIPE_CTRL_WDOG_EN, WDOG_LIMIT=10: hold stallreq_ex_i 12 cycles → wdog_timeout_o rises after the 10th stalled cycle and stays high after the request drops, until rst.
